axis_frame_marker: RTL and testbench



---
 rtl/axis_frame_marker.sv | 136 +++++++++++++
 tb/tb_axis_frame_marker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_marker.sv
// axis_frame_marker: resynchronises a {misc, cntr, sample} stream on cntr==0,
// prefixes every frame with a header word, marks the last word with tlast and
// tracks counter continuity (sticky error) plus a completed-frame count.
module axis_frame_marker #(
  parameter int DATA_WIDTH       = 32,
  parameter int CNTR_WIDTH       = 16,
  parameter int MISC_WIDTH       = 16,
  parameter int AXIS_TDATA_WIDTH = 64  // MISC_WIDTH + CNTR_WIDTH + DATA_WIDTH
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic [DATA_WIDTH-1:0]       sts_frames,
  output logic                        sts_error
);

  typedef enum logic [1:0] {SYNC, HEAD, HOLD, DATA} state_t;

  state_t                      state, state_nx;
  logic [AXIS_TDATA_WIDTH-1:0] hold_reg;
  logic [CNTR_WIDTH-1:0]       len_reg;
  logic [CNTR_WIDTH-1:0]       expected, exp_nx;

  logic                        slot_free;
  logic [CNTR_WIDTH-1:0]       s_cntr;
  logic [MISC_WIDTH-1:0]       hold_misc;

  // next-state decode results
  logic                        cap;      // frame start: capture word and length
  logic                        ld;       // load output slot
  logic [AXIS_TDATA_WIDTH-1:0] ld_data;
  logic                        ld_last;
  logic                        err_set;

  assign slot_free = ~m_axis_tvalid | m_axis_tready;
  assign s_cntr    = s_axis_tdata[DATA_WIDTH+CNTR_WIDTH-1:DATA_WIDTH];
  assign hold_misc = hold_reg[AXIS_TDATA_WIDTH-1 -: MISC_WIDTH];

  // frame sequencing: sync on cntr==0, emit header, replay held word, stream data
  always_comb begin
    state_nx      = state;
    exp_nx        = expected;
    s_axis_tready = 1'b0;
    cap           = 1'b0;
    ld            = 1'b0;
    ld_data       = '0;
    ld_last       = 1'b0;
    err_set       = 1'b0;
    case (state)
      SYNC: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_cntr == '0) begin
          cap      = 1'b1;
          state_nx = HEAD;
        end
      end
      HEAD: begin
        if (slot_free) begin
          ld       = 1'b1;
          ld_data  = {hold_misc, len_reg, sts_frames};
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (slot_free) begin
          ld       = 1'b1;
          ld_data  = hold_reg;
          ld_last  = (len_reg == '0);
          exp_nx   = CNTR_WIDTH'(1);
          state_nx = (len_reg == '0) ? SYNC : DATA;
        end
      end
      DATA: begin
        s_axis_tready = slot_free;
        if (s_axis_tvalid && slot_free) begin
          ld      = 1'b1;
          ld_data = s_axis_tdata;
          if (s_cntr == expected) begin
            ld_last = (s_cntr == len_reg);
            exp_nx  = expected + CNTR_WIDTH'(1);
          end else begin
            // discontinuity: close the frame here; this word never starts a frame
            ld_last = 1'b1;
            err_set = 1'b1;
          end
          if (ld_last) state_nx = SYNC;
        end
      end
      default: state_nx = SYNC;
    endcase
  end

  // state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= SYNC;
    else        state <= state_nx;
  end

  // datapath: hold/length capture, output slot, status counters
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hold_reg      <= '0;
      len_reg       <= '0;
      expected      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      sts_frames    <= '0;
      sts_error     <= 1'b0;
    end else begin
      if (cap) begin
        hold_reg <= s_axis_tdata;
        len_reg  <= cfg_data;
      end
      expected <= exp_nx;
      if (ld) begin
        m_axis_tdata  <= ld_data;
        m_axis_tlast  <= ld_last;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
        sts_frames <= sts_frames + DATA_WIDTH'(1);
      if (err_set) sts_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_frame_marker.sv
// Directed bench for axis_frame_marker: input words are pushed through a
// handshake task, a negedge monitor collects output beats and checks stability
// under backpressure, and each scenario is compared to a hand-built word list.
module tb_axis_frame_marker;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [15:0] cfg_data = '0;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        m_axis_tready = 1'b1;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic [31:0] sts_frames;
  logic        sts_error;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_rdy = 1'b0;

  logic [64:0] out_q[$];
  logic [64:0] exp_q[$];
  logic [64:0] msk_q[$];

  axis_frame_marker dut (
    .aclk(aclk), .areset(areset), .cfg_data(cfg_data),
    .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .sts_frames(sts_frames), .sts_error(sts_error)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] hw(input logic [15:0] misc, input logic [15:0] len, input logic [31:0] seq);
    return {1'b0, misc, len, seq};
  endfunction

  function automatic logic [64:0] dw(input logic last, input logic [15:0] misc, input logic [15:0] cntr, input logic [31:0] smp);
    return {last, misc, cntr, smp};
  endfunction

  task automatic expect_w(input logic [64:0] w);
    exp_q.push_back(w);
    msk_q.push_back({65{1'b1}});
  endtask

  // header with the sequence field excluded from comparison
  task automatic expect_hdr_noseq(input logic [15:0] misc, input logic [15:0] len);
    exp_q.push_back(hw(misc, len, 32'h0));
    msk_q.push_back({{33{1'b1}}, 32'h0});
  endtask

  // output monitor: beats are stable mid-cycle; a beat with valid&ready here
  // completes on the next rising edge
  logic        prev_stall = 1'b0;
  logic [64:0] prev_w = '0;
  initial forever begin
    @(negedge aclk);
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_w});
      if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tlast, m_axis_tdata});
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_w     = {m_axis_tlast, m_axis_tdata};
    end
  end

  // random downstream backpressure when enabled
  initial forever begin
    @(posedge aclk);
    #2;
    if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
  end

  task automatic push(input logic [15:0] misc, input logic [15:0] cntr, input logic [31:0] smp);
    int n;
    s_axis_tdata  = {misc, cntr, smp};
    s_axis_tvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!s_axis_tready && n < 500) begin
      n++;
      @(negedge aclk);
    end
    if (n >= 500) chk("push_timeout", 96'(n), 96'(0));
    @(posedge aclk);
    #2;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  task automatic do_reset();
    #3 areset = 1'b1;
    idle(3);
    areset = 1'b0;
    out_q.delete();
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, "_nwords"}, 96'(out_q.size()), 96'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_w%0d", tag, i), 96'(out_q[i] & msk_q[i]), 96'(exp_q[i]));
    out_q.delete();
    exp_q.delete();
    msk_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    #12;
    chk("rst_tvalid", 96'(m_axis_tvalid), 96'(0));
    chk("rst_tdata",  96'(m_axis_tdata),  96'(0));
    chk("rst_frames", 96'(sts_frames),    96'(0));
    chk("rst_error",  96'(sts_error),     96'(0));
    do_reset();
    chk("rst_sready", 96'(s_axis_tready), 96'(1));

    // basic frame of 4
    cfg_data = 16'd3;
    for (int i = 0; i < 4; i++) push(16'h0A00 + 16'(i), 16'(i), 32'(10 + i));
    idle(6);
    expect_w(hw(16'h0A00, 16'd3, 32'd0));
    for (int i = 0; i < 4; i++) expect_w(dw(i == 3, 16'h0A00 + 16'(i), 16'(i), 32'(10 + i)));
    compare("basic");
    chk("basic_frames", 96'(sts_frames), 96'(1));
    chk("basic_error",  96'(sts_error),  96'(0));

    // start mid-frame: cntr 2,3 discarded
    do_reset();
    begin
      logic [15:0] seqc[6];
      seqc = '{16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3};
      for (int i = 0; i < 6; i++) push(16'h0B00 + 16'(i), seqc[i], 32'(20 + i));
    end
    idle(6);
    expect_w(hw(16'h0B02, 16'd3, 32'd0));
    for (int i = 0; i < 4; i++) expect_w(dw(i == 3, 16'h0B02 + 16'(i), 16'(i), 32'(22 + i)));
    compare("midsync");
    chk("midsync_frames", 96'(sts_frames), 96'(1));

    // single-word frames
    do_reset();
    cfg_data = 16'd0;
    for (int i = 0; i < 3; i++) push(16'h0C00 + 16'(i), 16'd0, 32'(30 + i));
    idle(6);
    for (int i = 0; i < 3; i++) begin
      expect_w(hw(16'h0C00 + 16'(i), 16'd0, 32'(i)));
      expect_w(dw(1'b1, 16'h0C00 + 16'(i), 16'd0, 32'(30 + i)));
    end
    compare("len1");
    chk("len1_frames", 96'(sts_frames), 96'(3));

    // discontinuity truncates the frame, error is sticky
    do_reset();
    cfg_data = 16'd3;
    push(16'h0D00, 16'd0, 32'd40);
    push(16'h0D01, 16'd1, 32'd41);
    push(16'h0D03, 16'd3, 32'd43);
    idle(6);
    expect_w(hw(16'h0D00, 16'd3, 32'd0));
    expect_w(dw(1'b0, 16'h0D00, 16'd0, 32'd40));
    expect_w(dw(1'b0, 16'h0D01, 16'd1, 32'd41));
    expect_w(dw(1'b1, 16'h0D03, 16'd3, 32'd43));
    compare("trunc");
    chk("trunc_error",  96'(sts_error),  96'(1));
    chk("trunc_frames", 96'(sts_frames), 96'(1));
    cfg_data = 16'd9;  // latched only at the next frame start, so this one is length 10
    for (int i = 0; i < 4; i++) push(16'h0E00, 16'(i), 32'(50 + i));
    cfg_data = 16'd3;  // mid-frame change must not shorten it
    for (int i = 4; i < 10; i++) push(16'h0E00, 16'(i), 32'(50 + i));
    idle(6);
    expect_w(hw(16'h0E00, 16'd9, 32'd1));
    for (int i = 0; i < 10; i++) expect_w(dw(i == 9, 16'h0E00, 16'(i), 32'(50 + i)));
    compare("recover");
    chk("recover_error",  96'(sts_error),  96'(1));
    chk("recover_frames", 96'(sts_frames), 96'(2));

    // 100 frames of 8 under random backpressure
    do_reset();
    cfg_data = 16'd7;
    rand_rdy = 1'b1;
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < 8; i++) push(16'(f), 16'(i), 32'(f * 8 + i));
      expect_hdr_noseq(16'(f), 16'd7);
      for (int i = 0; i < 8; i++) expect_w(dw(i == 7, 16'(f), 16'(i), 32'(f * 8 + i)));
    end
    rand_rdy = 1'b0;
    idle(1);
    m_axis_tready = 1'b1;
    idle(10);
    compare("rand");
    chk("rand_frames", 96'(sts_frames), 96'(100));

    // asynchronous reset in the middle of a frame
    cfg_data = 16'd3;
    push(16'h0F00, 16'd0, 32'd60);
    push(16'h0F01, 16'd1, 32'd61);
    m_axis_tready = 1'b0;          // keep the second data word parked in the slot
    #3;
    chk("pre_rst_tvalid", 96'(m_axis_tvalid), 96'(1));
    areset = 1'b1;
    #1;
    chk("async_tvalid", 96'(m_axis_tvalid), 96'(0));
    chk("async_tlast",  96'(m_axis_tlast),  96'(0));
    chk("async_tdata",  96'(m_axis_tdata),  96'(0));
    chk("async_frames", 96'(sts_frames),    96'(0));
    m_axis_tready = 1'b1;
    idle(3);
    areset = 1'b0;
    out_q.delete();
    for (int i = 0; i < 4; i++) push(16'h1000, 16'(i), 32'(70 + i));
    idle(6);
    expect_w(hw(16'h1000, 16'd3, 32'd0));
    for (int i = 0; i < 4; i++) expect_w(dw(i == 3, 16'h1000, 16'(i), 32'(70 + i)));
    compare("post_rst");
    chk("post_rst_frames", 96'(sts_frames), 96'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
